// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the MIPS execute stage.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; both retire one
// bit per cycle, so every operation takes the same fixed latency.  Signed ops
// run on operand magnitudes and the signs are applied on the final write.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;      // {partial hi, shifting operand}
   logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   rs_q, rs_d;        // raw dividend, for divide-by-zero
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;  // negate product / quotient
   logic               neg_rem_q, neg_rem_d;  // negate remainder
   logic               dz_q, dz_d;            // divide by zero
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   // Operand magnitudes for the op being launched (op[0]=0 means signed).
   logic             op_signed, rs_neg, rt_neg;
   logic [WIDTH-1:0] rs_mag, rt_mag;

   // One iteration of each algorithm, plus the sign-corrected final results.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_rem_sh;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // Launch-time operand preparation; |0x80000000| wraps to unsigned 2^31.
   always_comb begin
      op_signed = ~op[0];
      rs_neg    = op_signed & rs_val[WIDTH-1];
      rt_neg    = op_signed & rt_val[WIDTH-1];
      rs_mag    = rs_neg ? (~rs_val + 1'b1) : rs_val;
      rt_mag    = rt_neg ? (~rt_val + 1'b1) : rt_val;
   end

   // Datapath step: shift-add multiply and restoring divide, one bit each.
   always_comb begin
      mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

      div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge     = div_rem_sh >= {1'b0, opnd_q};
      div_diff   = div_rem_sh[WIDTH-1:0] - opnd_q;
      div_next   = {(div_ge ? div_diff : div_rem_sh[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], div_ge};

      acc_step   = is_div_q ? div_next : mul_next;

      prod_fix   = neg_res_q ? (~acc_step + 1'b1) : acc_step;
      quo_fix    = neg_res_q ? (~acc_step[WIDTH-1:0] + 1'b1)
                             : acc_step[WIDTH-1:0];
      rem_fix    = neg_rem_q ? (~acc_step[2*WIDTH-1:WIDTH] + 1'b1)
                             : acc_step[2*WIDTH-1:WIDTH];
   end

   // Next-state logic: launch, iterate, final write and HI/LO moves.
   always_comb begin
      // NOTE: every _d gets a default first so no path leaves a latch behind.
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      rs_d      = rs_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      unique case (state_q)
         S_RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = S_DONE;
               if (!is_div_q) begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end else if (dz_q) begin
                  hi_d = rs_q;
                  lo_d = {WIDTH{1'b1}};
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         default: begin  // S_IDLE, S_DONE: not busy
            if (start) begin
               // start wins over any mthi/mtlo in the same cycle
               state_d   = S_RUN;
               cnt_d     = '0;
               is_div_d  = op[1];
               neg_res_d = rs_neg ^ rt_neg;
               neg_rem_d = rs_neg;
               dz_d      = op[1] & (rt_val == '0);
               rs_d      = rs_val;
               acc_d     = op[1] ? {{WIDTH{1'b0}}, rs_mag} : {{WIDTH{1'b0}}, rt_mag};
               opnd_d    = op[1] ? rt_mag : rs_mag;
            end else begin
               state_d = S_IDLE;
               if (mthi) hi_d = wdata;
               if (mtlo) lo_d = wdata;
            end
         end
      endcase
   end

   // State and datapath registers; async reset abandons any operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         rs_q      <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         rs_q      <= rs_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: an arithmetic reference model with a
// cycle countdown, a per-cycle compare process, and directed vectors whose
// results are also pinned by hand-computed constants.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
      .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference result {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] model_res(input logic [1:0] o,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, p, q, r;
      logic [63:0] ua, ub, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         2'd0: begin p = sa * sb; return p; end
         2'd1: return ua * ub;
         2'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
      endcase
   endfunction

   // Behavioural model: a busy countdown of 32 cycles, then result + done.
   int          rem_m  = 0;
   logic        done_m = 1'b0;
   logic [31:0] hi_m = '0, lo_m = '0;
   logic [63:0] pend_m = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem_m  = 0;
         done_m = 1'b0;
         hi_m   = '0;
         lo_m   = '0;
      end else if (rem_m > 0) begin
         rem_m  = rem_m - 1;
         done_m = 1'b0;
         if (rem_m == 0) begin
            hi_m   = pend_m[63:32];
            lo_m   = pend_m[31:0];
            done_m = 1'b1;
         end
      end else begin
         done_m = 1'b0;
         if (start) begin
            pend_m = model_res(op, rs_val, rt_val);
            rem_m  = 32;
         end else begin
            if (mthi) hi_m = wdata;
            if (mtlo) lo_m = wdata;
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_busy", {63'd0, busy}, {63'd0, (rem_m > 0)});
         check("cyc_done", {63'd0, done}, {63'd0, done_m});
         check("cyc_hi", {32'd0, hi}, {32'd0, hi_m});
         check("cyc_lo", {32'd0, lo}, {32'd0, lo_m});
      end
   end

   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Waits (bounded) for done; done must appear 32 edges after the start edge.
   task automatic wait_done(input int n0, input string nm,
                            input logic [31:0] eh, input logic [31:0] el);
      int n = n0;
      bit seen = 1'b0;
      while (n < 40 && !seen) begin
         @(posedge clk);
         #1;
         n++;
         if (done) seen = 1'b1;
      end
      check({nm, "_lat"}, n, 32);
      check({nm, "_hi"}, {32'd0, hi}, {32'd0, eh});
      check({nm, "_lo"}, {32'd0, lo}, {32'd0, el});
   endtask

   task automatic move(input logic h, input logic l, input logic [31:0] d);
      mthi  = h;
      mtlo  = l;
      wdata = d;
      @(posedge clk);
      #1 mthi = 1'b0;
      mtlo = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 cmp_en = 1'b1;
      check("rst_busy", {63'd0, busy}, 0);
      check("rst_done", {63'd0, done}, 0);
      check("rst_hi", {32'd0, hi}, 0);
      check("rst_lo", {32'd0, lo}, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Preload HI/LO so the mid-run reset visibly clears them.
      move(1'b1, 1'b1, 32'hA5A5_5A5A);
      check("pre_hi", {32'd0, hi}, 64'hA5A5_5A5A);
      check("pre_lo", {32'd0, lo}, 64'hA5A5_5A5A);

      // Reset during the tenth RUN cycle of a MULT.
      launch(2'd0, 32'h0000_1234, 32'h0000_0010);
      repeat (9) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_busy", {63'd0, busy}, 0);
      check("mid_rst_done", {63'd0, done}, 0);
      check("mid_rst_hi", {32'd0, hi}, 0);
      check("mid_rst_lo", {32'd0, lo}, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      launch(2'd1, 32'd5, 32'd6);
      wait_done(0, "multu_5x6", 32'd0, 32'd30);
      launch(2'd0, 32'hFFFF_FFFE, 32'd3);
      wait_done(0, "mult_m2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      launch(2'd1, 32'hFFFF_FFFE, 32'd3);
      wait_done(0, "multu_big", 32'h0000_0002, 32'hFFFF_FFFA);
      launch(2'd2, 32'hFFFF_FFF9, 32'd2);
      wait_done(0, "div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      launch(2'd3, 32'd100, 32'd7);
      wait_done(0, "divu_100_7", 32'd2, 32'd14);
      launch(2'd3, 32'd7, 32'd0);
      wait_done(0, "divu_by0", 32'd7, 32'hFFFF_FFFF);
      launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(0, "div_ovf", 32'd0, 32'h8000_0000);
      launch(2'd2, 32'hFFFF_FFF9, 32'd0);
      wait_done(0, "div_by0_neg", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      launch(2'd0, 32'h8000_0000, 32'h8000_0000);
      wait_done(0, "mult_minmin", 32'h4000_0000, 32'h0000_0000);

      // start + mthi while busy: both ignored.
      launch(2'd1, 32'd2, 32'd3);
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      op     = 2'd3;
      rs_val = 32'd9;
      rt_val = 32'd3;
      mthi   = 1'b1;
      wdata  = 32'h0000_DEAD;
      @(posedge clk);
      #1 start = 1'b0;
      mthi = 1'b0;
      wait_done(5, "busy_ignore", 32'd0, 32'd6);

      // Back-to-back start from DONE.
      launch(2'd3, 32'd100, 32'd7);
      check("b2b_done", {63'd0, done}, 0);
      check("b2b_busy", {63'd0, busy}, 1);
      wait_done(0, "b2b_divu", 32'd2, 32'd14);

      // mthi/mtlo with start in the same cycle: start wins.
      mtlo  = 1'b1;
      wdata = 32'h0BAD_0BAD;
      launch(2'd1, 32'd7, 32'd8);
      mtlo = 1'b0;
      wait_done(0, "mt_vs_start", 32'd0, 32'd56);

      move(1'b0, 1'b1, 32'h0000_1234);
      check("mtlo_lo", {32'd0, lo}, 64'h1234);
      check("mtlo_hi", {32'd0, hi}, 64'h0);
      move(1'b1, 1'b1, 32'hCAFE_F00D);
      check("both_hi", {32'd0, hi}, 64'hCAFE_F00D);
      check("both_lo", {32'd0, lo}, 64'hCAFE_F00D);

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative HI/LO multiply/divide unit for the MIPS execute stage. Implements MULT, MULTU, DIV and DIVU, plus MTHI and MTLO.
Its registered hi and lo outputs feed the execute-stage result MUX directly as data inputs B and C. The ALU result drives input A, and the MFHI/MFLO decode drives cntl.
Pipeline control stalls on busy.

Parameters:
WIDTH, 32, operand/result width; hi and lo are each WIDTH bits.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
clk  input  1  rising-edge clock, single clock domain.
reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
start  input  1  launch operation; sampled on rising edge.
op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start.
rs_val  input  WIDTH  multiplicand or dividend.
rt_val  input  WIDTH  multiplier or divisor.
mthi  input  1  write wdata to hi.
mtlo  input  1  write wdata to lo.
wdata  input  WIDTH  data for mthi/mtlo.
busy  output  1  high while an iteration is in progress.
done  output  1  one-cycle pulse when hi/lo hold a new result.
hi  output  WIDTH  HI register; to MUX input B.
lo  output  WIDTH  LO register; to MUX input C.

Behaviour:
- Reset (reset=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. An in-flight operation is abandoned with no partial write.
- FSM states IDLE, RUN, DONE.
- IDLE/DONE with start=1: capture op and operands, go to RUN, counter=0.
- IDLE/DONE with start=0: DONE returns to IDLE; IDLE stays in IDLE.
- RUN: one iteration per cycle, counter increments each cycle. When counter=WIDTH-1, write results to hi/lo on that edge and go to DONE.
- busy = (state==RUN).
- done = (state==DONE); it is exactly one cycle wide unless a back-to-back start occurs.
- Latency: start sampled at edge k; RUN occupies cycles k+1..k+32; new hi/lo and done=1 appear in cycle k+33. Latency is fixed at 33 cycles for every op, including divide-by-zero.
- start while busy=1: ignored, with no effect on the in-flight operation.
- Signed ops (MULT, DIV): take the magnitudes of the operands, run the unsigned algorithm, then fix signs on the final write.
  - Product sign = sign(rs) XOR sign(rt).
  - Quotient sign = sign(rs) XOR sign(rt).
  - Remainder sign = sign of the dividend.
  - |0x80000000| is treated as unsigned 2^31.
- Multiply: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator. Result: hi = product[63:32], lo = product[31:0].
- Divide: restoring divide, one quotient bit per cycle. Result: lo = quotient, hi = remainder.
- Divide by zero (rt_val=0, DIV or DIVU): lo=0xFFFFFFFF, hi=rs_val unchanged. This holds for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is not an error case.
- mthi/mtlo: honoured only when busy=0.
  - They write hi/lo at the next edge.
  - mthi and mtlo may both be asserted in the same cycle.
- Collisions:
  - mthi/mtlo with start in the same cycle: start wins and the writes are dropped.
  - mthi/mtlo while busy: dropped.
- hi/lo change only on: reset, result write, or an honoured mthi/mtlo.

Test Plan:
- Reset low mid-RUN at cycle 10 of a MULT -> busy=0, done=0, hi=lo=0 immediately. After reset releases, start MULTU 5*6 -> lo=30, hi=0 at cycle k+33.
- MULT rs=0xFFFFFFFE, rt=3 -> done at k+33 with hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 -> lo=14, hi=2.
- DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7, still 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULTU 2*3 started; at cycle k+5 assert start (DIVU 9/3) plus mthi with wdata=0xDEAD -> both ignored; hi=0, lo=6 at k+33.
- In DONE, issue a back-to-back start -> accepted, done drops the next cycle.
- Then mtlo=1 with wdata=0x1234 while idle -> lo=0x1234 at the next edge.
- mthi and mtlo together -> both equal wdata.
